// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- pipeline memory stage in front of a byte-wide synchronous RAM.
//
// Loads and stores of 1, 2 or 4 bytes are split into single-byte accesses:
// one byte per cycle, little-endian, at consecutive addresses (addr+k with
// 32-bit wrap). Byte 0 is issued in the accept cycle. Read data appears one
// cycle after its address. While bytes are in flight stall_req_o freezes the
// upstream stages. The final DONE state presents the assembled and extended
// load result. DONE holds while stall_i[4] is set. Non-memory instructions
// pass straight through to writeback without any state change.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   stall_i            pipeline hold vector, bit 4 = mem-stage hold
//   wd_i, wreg_i       destination register / write enable from execute
//   data_i             ALU result, or store data for stores
//   opcode_i, op_i     instruction class and load/store subtype
//   mem_addr_i         effective byte address
//   wd_o, wreg_o,
//   wdata_o            results to writeback
//   mem_a_o, mem_wr_o,
//   mem_dout_o,
//   mem_din_i          byte-wide synchronous RAM port
//   stall_req_o        freeze request to the pipeline controller
//   access_cnt_o       (MEM_ACCESS_CNT_EN only) completed load/store count
//
// Optional feature: define MEM_ACCESS_CNT_EN to add access_cnt_o, a wrapping
// 32-bit count of load/store instructions retired on DONE -> IDLE.
// -----------------------------------------------------------------------------
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef OptcodeBus
`define OptcodeBus 6:0
`endif
`ifndef OpBus
`define OpBus 2:0
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef OptcodeLoad
`define OptcodeLoad 7'b0000011
`endif
`ifndef OptcodeSave
`define OptcodeSave 7'b0100011
`endif
`ifndef WriteDisable
`define WriteDisable 1'b0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

module mem_stage (
  input  logic                clk,
  input  logic                rst,
  input  logic [`StallBus]    stall_i,
  input  logic [`RegAddrBus]  wd_i,
  input  logic                wreg_i,
  input  logic [`RegBus]      data_i,
  input  logic [`OptcodeBus]  opcode_i,
  input  logic [`OpBus]       op_i,
  input  logic [`InstAddrBus] mem_addr_i,
  output logic [`RegAddrBus]  wd_o,
  output logic                wreg_o,
  output logic [`RegBus]      wdata_o,
  output logic [31:0]         mem_a_o,
  output logic                mem_wr_o,
  output logic [7:0]          mem_dout_o,
  input  logic [7:0]          mem_din_i,
  output logic                stall_req_o
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [31:0]         access_cnt_o
`endif
);

  // Load subtypes; stores reuse the low two bits for their size.
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [`RegBus]     data_q, data_d;
  logic [`OpBus]      op_q, op_d;
  logic               is_load_q, is_load_d;
  logic [`RegAddrBus] wd_q, wd_d;
  logic               wreg_q, wreg_d;
  logic [31:0]        ld_q, ld_d;
  logic               fresh_q, fresh_d;
`ifdef MEM_ACCESS_CNT_EN
  logic [31:0]        access_cnt_q, access_cnt_d;
`endif

  logic [`RegAddrBus] wd_s;
  logic               wreg_s;
  logic [`RegBus]     wdata_s;
  logic [31:0]        mem_a_s;
  logic               mem_wr_s;
  logic [7:0]         mem_dout_s;
  logic               stall_req_s;
  logic               is_mem_s;
  logic [2:0]         last_idx_s;
  logic [31:0]        raw_s;

  // Only the mem-stage hold bit matters here.
  logic [4:0]         stall_unused_s;
  assign stall_unused_s = {stall_i[5], stall_i[3:0]};

  function automatic logic [2:0] access_size(input logic [2:0] op);
    case (op[1:0])
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    get_byte = w[7:0];
      2'd1:    get_byte = w[15:8];
      2'd2:    get_byte = w[23:16];
      default: get_byte = w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    put_byte = r;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] raw);
    case (op)
      OP_LB:   extend = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   extend = {{16{raw[15]}}, raw[15:0]};
      OP_LW:   extend = raw;
      OP_LBU:  extend = {24'd0, raw[7:0]};
      OP_LHU:  extend = {16'd0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  // Next-state logic and combinational memory/writeback outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    op_d        = op_q;
    is_load_d   = is_load_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    ld_d        = ld_q;
    fresh_d     = fresh_q;
`ifdef MEM_ACCESS_CNT_EN
    access_cnt_d = access_cnt_q;
`endif
    wd_s        = 5'd0;
    wreg_s      = 1'b0;
    wdata_s     = 32'd0;
    mem_a_s     = 32'd0;
    mem_wr_s    = 1'b0;
    mem_dout_s  = 8'd0;
    stall_req_s = 1'b0;
    is_mem_s    = (opcode_i == `OptcodeLoad) || (opcode_i == `OptcodeSave);
    last_idx_s  = access_size(op_q) - 3'd1;
    raw_s       = ld_q;

    case (state_q)
      ST_IDLE: begin
        if (is_mem_s) begin
          addr_d      = mem_addr_i;
          data_d      = data_i;
          op_d        = op_i;
          is_load_d   = (opcode_i == `OptcodeLoad);
          wd_d        = wd_i;
          wreg_d      = wreg_i;
          ld_d        = 32'd0;
          // Byte 0 goes out in the accept cycle itself.
          mem_a_s     = mem_addr_i;
          mem_wr_s    = (opcode_i == `OptcodeSave);
          mem_dout_s  = (opcode_i == `OptcodeSave) ? data_i[7:0] : 8'd0;
          stall_req_s = 1'b1;
          wd_s        = wd_i;
          if (access_size(op_i) == 3'd1) begin
            state_d = ST_DONE;
            cnt_d   = 2'd0;
            fresh_d = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = 2'd1;
            fresh_d = 1'b0;
          end
        end else begin
          wd_s    = wd_i;
          wreg_s  = wreg_i;
          wdata_s = data_i;
        end
      end

      ST_ACCESS: begin
        mem_a_s     = addr_q + {30'd0, cnt_q};
        stall_req_s = 1'b1;
        wd_s        = wd_q;
        if (is_load_q) begin
          // Data for the byte issued last cycle is on mem_din_i now.
          ld_d = put_byte(ld_q, cnt_q - 2'd1, mem_din_i);
        end else begin
          mem_wr_s   = 1'b1;
          mem_dout_s = get_byte(data_q, cnt_q);
        end
        if ({1'b0, cnt_q} == last_idx_s) begin
          state_d = ST_DONE;
          cnt_d   = 2'd0;
          fresh_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      ST_DONE: begin
        // Last load byte arrives in the first DONE cycle; keep it so the
        // result stays stable however long DONE is held.
        if (fresh_q && is_load_q) begin
          raw_s = put_byte(ld_q, last_idx_s[1:0], mem_din_i);
        end else begin
          raw_s = ld_q;
        end
        ld_d    = raw_s;
        fresh_d = 1'b0;
        wd_s    = wd_q;
        wreg_s  = is_load_q ? wreg_q : 1'b0;
        wdata_s = is_load_q ? extend(op_q, raw_s) : 32'd0;
        if (!stall_i[4]) begin
          state_d = ST_IDLE;
`ifdef MEM_ACCESS_CNT_EN
          access_cnt_d = access_cnt_q + 32'd1;
`endif
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    // Reset overrides the outputs at once, even mid-access.
    if (rst) begin
      wd_o        = 5'd0;
      wreg_o      = `WriteDisable;
      wdata_o     = `ZeroWord;
      mem_a_o     = 32'd0;
      mem_wr_o    = 1'b0;
      mem_dout_o  = 8'd0;
      stall_req_o = 1'b0;
    end else begin
      wd_o        = wd_s;
      wreg_o      = wreg_s;
      wdata_o     = wdata_s;
      mem_a_o     = mem_a_s;
      mem_wr_o    = mem_wr_s;
      mem_dout_o  = mem_dout_s;
      stall_req_o = stall_req_s;
    end
  end

  // State, byte counter and instruction latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      op_q      <= 3'd0;
      is_load_q <= 1'b0;
      wd_q      <= 5'd0;
      wreg_q    <= 1'b0;
      ld_q      <= 32'd0;
      fresh_q   <= 1'b0;
`ifdef MEM_ACCESS_CNT_EN
      access_cnt_q <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      op_q      <= op_d;
      is_load_q <= is_load_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      ld_q      <= ld_d;
      fresh_q   <= fresh_d;
`ifdef MEM_ACCESS_CNT_EN
      access_cnt_q <= access_cnt_d;
`endif
    end
  end

`ifdef MEM_ACCESS_CNT_EN
  assign access_cnt_o = access_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// A byte RAM model serves the DUT; a separate shadow memory plus arithmetic
// reference predicts load results, written bytes and stall lengths.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_SAVE = 7'b0100011;
  localparam logic [6:0] OPC_ALU  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] data_i;
  logic [6:0]  opcode_i;
  logic [2:0]  op_i;
  logic [31:0] mem_addr_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic [7:0]  mem_dout_o;
  logic [7:0]  mem_din_i;
  logic        stall_req_o;
`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] access_cnt_o;
  int unsigned exp_cnt = 0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ram    [0:4095];
  logic [7:0]  shadow [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_a  = 12'd0;
  logic [7:0]  pl_d  = 8'd0;

  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t wlog[$];

  mem_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .data_i(data_i), .opcode_i(opcode_i), .op_i(op_i), .mem_addr_i(mem_addr_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .mem_a_o(mem_a_o),
    .mem_wr_o(mem_wr_o), .mem_dout_o(mem_dout_o), .mem_din_i(mem_din_i),
    .stall_req_o(stall_req_o)
`ifdef MEM_ACCESS_CNT_EN
    , .access_cnt_o(access_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM with a backdoor preload port and a write log.
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_a] <= pl_d;
    end else if (mem_wr_o) begin
      ram[mem_a_o[11:0]] <= mem_dout_o;
      wlog.push_back('{a: mem_a_o, d: mem_dout_o});
    end
    mem_din_i <= ram[mem_a_o[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] op);
    if (op == 3'b010) return 4;          // LW / SW
    if (op == 3'b001 || op == 3'b101) return 2;  // LH / LHU / SH
    return 1;                             // LB / LBU / SB
  endfunction

  // Reference load: gather bytes little-endian, then sign-adjust signed loads.
  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
    int n;
    longint v;
    logic [11:0] idx;
    n = size_of(op);
    v = 0;
    for (int k = 0; k < n; k++) begin
      idx = 12'(addr + 32'(k));
      v = v + longint'(shadow[idx]) * (longint'(1) << (8 * k));
    end
    if (!op[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic scramble();
    opcode_i   = ($urandom_range(0, 1) == 0) ? OPC_LOAD : OPC_SAVE;
    op_i       = 3'($urandom);
    mem_addr_i = $urandom;
    data_i     = $urandom;
    wd_i       = 5'($urandom);
    wreg_i     = 1'($urandom);
  endtask

  // One load/store from accept to return to IDLE, checked cycle by cycle.
  task automatic do_mem(input bit is_load, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input int hold, input logic wr_in,
                        output logic [31:0] got);
    int n, stalls;
    logic [4:0] wd;
    logic [31:0] exp_w, done_a;
    logic [11:0] idx;
    n  = size_of(op);
    wd = 5'($urandom);
    exp_w = is_load ? model_load(op, addr) : 32'd0;
    @(negedge clk);
    opcode_i = is_load ? OPC_LOAD : OPC_SAVE;
    op_i = op; mem_addr_i = addr; data_i = data; wd_i = wd; wreg_i = wr_in;
    stall_i = 6'd0;
    wlog.delete();
    stalls = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (stall_req_o !== 1'b1) break;
      check("issue_addr", mem_a_o, addr + 32'(c));
      check("issue_wr", {31'd0, mem_wr_o}, {31'd0, !is_load});
      if (!is_load) check("issue_dout", {24'd0, mem_dout_o}, (data >> (8 * c)) & 32'hFF);
      stalls++;
      @(posedge clk); #1;
      scramble();
      @(negedge clk);
    end
    check("stall_cycles", 32'(stalls), 32'(n));
    got = wdata_o;
    done_a = mem_a_o;
    check("done_wdata", wdata_o, exp_w);
    check("done_wd", {27'd0, wd_o}, {27'd0, wd});
    check("done_wreg", {31'd0, wreg_o}, {31'd0, is_load ? wr_in : 1'b0});
    check("done_wr", {31'd0, mem_wr_o}, 32'd0);
    check("wlog_size", 32'(wlog.size()), is_load ? 32'd0 : 32'(n));
    if (!is_load) begin
      for (int k = 0; k < n && k < wlog.size(); k++) begin
        check("wr_addr", wlog[k].a, addr + 32'(k));
        check("wr_data", {24'd0, wlog[k].d}, (data >> (8 * k)) & 32'hFF);
      end
      idx = 12'(addr + 32'(n));
      check("untouched", {24'd0, ram[idx]}, {24'd0, shadow[idx]});
      for (int k = 0; k < n; k++) begin
        idx = 12'(addr + 32'(k));
        shadow[idx] = 8'((data >> (8 * k)) & 32'hFF);
      end
    end
    if (hold > 0) begin
      stall_i[4] = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); @(negedge clk); #1;
        check("hold_wdata", wdata_o, got);
        check("hold_addr", mem_a_o, done_a);
        check("hold_stall", {31'd0, stall_req_o}, 32'd0);
        check("hold_wr", {31'd0, mem_wr_o}, 32'd0);
      end
    end
    stall_i  = 6'd0;
    opcode_i = OPC_ALU;
    @(posedge clk); #1;
    check("idle_after", {31'd0, stall_req_o}, 32'd0);
`ifdef MEM_ACCESS_CNT_EN
    exp_cnt++;
    check("access_cnt", access_cnt_o, 32'(exp_cnt));
`endif
  endtask

  // Non-memory instruction: same-cycle pass-through, no stall, no write.
  task automatic alu_op(input logic [31:0] data, input logic [4:0] wd, input logic wr);
    @(negedge clk);
    opcode_i = OPC_ALU; op_i = 3'($urandom); mem_addr_i = $urandom;
    data_i = data; wd_i = wd; wreg_i = wr; stall_i = 6'd0;
    #1;
    check("alu_wdata", wdata_o, data);
    check("alu_wd", {27'd0, wd_o}, {27'd0, wd});
    check("alu_wreg", {31'd0, wreg_o}, {31'd0, wr});
    check("alu_stall", {31'd0, stall_req_o}, 32'd0);
    check("alu_wr", {31'd0, mem_wr_o}, 32'd0);
    @(posedge clk); #1;
    check("alu_nostate", {31'd0, stall_req_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] got, a, d;
    logic [2:0] load_ops [5];
    logic [31:0] last_st;
    load_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    last_st = 32'h0000_0400;

    rst = 1'b1; stall_i = 6'd0;
    opcode_i = OPC_SAVE; op_i = 3'b010; mem_addr_i = 32'h40; data_i = 32'hDEADBEEF;
    wd_i = 5'd7; wreg_i = 1'b1;
    for (int i = 0; i < 4096; i++) shadow[i] = 8'($urandom);
    shadow[12'h100] = 8'h78; shadow[12'h101] = 8'h56;
    shadow[12'h102] = 8'h34; shadow[12'h103] = 8'h12;
    shadow[12'h020] = 8'h80; shadow[12'h206] = 8'h5A;
    #1;
    check("rst_wr", {31'd0, mem_wr_o}, 32'd0);
    check("rst_stall", {31'd0, stall_req_o}, 32'd0);
    check("rst_a", mem_a_o, 32'd0);
    check("rst_dout", {24'd0, mem_dout_o}, 32'd0);
    check("rst_wd", {27'd0, wd_o}, 32'd0);
    check("rst_wreg", {31'd0, wreg_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
`ifdef MEM_ACCESS_CNT_EN
    check("rst_cnt", access_cnt_o, 32'd0);
`endif
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk); pl_en = 1'b1; pl_a = 12'(i); pl_d = shadow[i];
    end
    @(negedge clk); pl_en = 1'b0; opcode_i = OPC_ALU;
    @(negedge clk); rst = 1'b0;

    // Directed cases.
    do_mem(1'b1, 3'b010, 32'h100, 32'h0, 3, 1'b1, got);
    check("lw_0x100", got, 32'h12345678);
    do_mem(1'b1, 3'b000, 32'h20, 32'h0, 0, 1'b1, got);
    check("lb_0x20", got, 32'hFFFFFF80);
    do_mem(1'b1, 3'b100, 32'h20, 32'h0, 0, 1'b1, got);
    check("lbu_0x20", got, 32'h00000080);
    do_mem(1'b0, 3'b001, 32'h204, 32'hAABBCCDD, 0, 1'b1, got);
    check("sh_0x206", {24'd0, ram[12'h206]}, 32'h5A);
    alu_op(32'h5, 5'd3, 1'b1);
    do_mem(1'b0, 3'b010, 32'hFFFF_FFFE, 32'hCAFEF00D, 1, 1'b0, got);
    do_mem(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h0, 0, 1'b1, got);
    check("lw_wrap", got, 32'hCAFEF00D);

    // Reset in the middle of a word store, while byte 2 is being issued.
    @(negedge clk);
    opcode_i = OPC_SAVE; op_i = 3'b010; mem_addr_i = 32'h300; data_i = 32'h11223344;
    wd_i = 5'd9; wreg_i = 1'b0; wlog.delete();
    repeat (2) @(posedge clk);
    #1;
    check("mid_b2_addr", mem_a_o, 32'h302);
    check("mid_b2_wr", {31'd0, mem_wr_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_wr", {31'd0, mem_wr_o}, 32'd0);
    check("mid_rst_stall", {31'd0, stall_req_o}, 32'd0);
    check("mid_rst_wdata", wdata_o, 32'd0);
    @(negedge clk); rst = 1'b0; opcode_i = OPC_ALU;
    shadow[12'h300] = 8'h44; shadow[12'h301] = 8'h33;
    @(posedge clk); #1;
    check("mid_wlog", 32'(wlog.size()), 32'd2);
    check("mid_b3", {24'd0, ram[12'h303]}, {24'd0, shadow[12'h303]});
    check("mid_b2", {24'd0, ram[12'h302]}, {24'd0, shadow[12'h302]});
`ifdef MEM_ACCESS_CNT_EN
    exp_cnt = 0;
    check("mid_cnt", access_cnt_o, 32'd0);
`endif
    alu_op(32'h0BAD_F00D, 5'd17, 1'b1);
    do_mem(1'b1, 3'b010, 32'h300, 32'h0, 0, 1'b1, got);

    // Randomised mix against the shadow model.
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 1) == 0) ? last_st : $urandom;
      d = $urandom;
      if (kind == 0) begin
        do_mem(1'b1, load_ops[$urandom_range(0, 4)], a, 32'h0,
               $urandom_range(0, 2), 1'($urandom), got);
      end else if (kind == 1) begin
        do_mem(1'b0, 3'($urandom_range(0, 2)), a, d, $urandom_range(0, 2), 1'($urandom), got);
        last_st = a;
      end else begin
        alu_op(d, 5'($urandom), 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
